sha256_stream: RTL and testbench
================================

# sha256_stream

Parametrised, multi-block SHA-256 compression engine. It is the next generation of the `sha256` core and the front stage of the Hash160 datapath, feeding RIPEMD-160.

- Accepts pre-padded 512-bit blocks over a ready/valid handshake.
- Chains the intermediate hash internally across blocks.
- Unrolls a configurable number of rounds per clock.
- Holds the final digest until the downstream stage takes it.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: rounds per clock. Legal values are 1, 2, 4 and 8; any other value fails elaboration.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `H_in` in 256: initial chaining value, sampled on an accepted block with `in_first`=1.
- `in_block` in 512: padded message block, word 0 in [511:480].
- `in_first` in 1: block starts a new message.
- `in_last` in 1: block ends the message.
- `in_valid` in 1: block offered.
- `in_ready` out 1: engine can accept a block.
- `mode224` in 1: SHA-224 select. Only used when `SHA256_SHA224_EN` is defined.
- `H_out` out 256: digest, word A in [255:224].
- `out_valid` out 1: digest valid.
- `out_ready` in 1: downstream takes the digest.

## Operation
- **States:** IDLE, ROUND, ADD, OUT. Reset sets IDLE.
- **Reset values:**
  - `out_valid`=0, `H_out`=0, round counter=0, internal chain H=0.
  - `in_ready`=0 while `rst`=1. Otherwise `in_ready` = (state==IDLE).
- **IDLE:** an accept occurs on a rising edge where `in_valid && in_ready`.
  - Chain source: `H_in` if `in_first`=1, else internal H.
  - Working variables a..h load from the chain source.
  - The 16-word W window loads from `in_block`.
  - Capture the `in_last` flag; counter=0; go to ROUND.
  - A non-first block arriving right after reset chains from H=0. This is defined behaviour and is not flagged.
- **ROUND:** each cycle applies `ROUNDS_PER_CYCLE` rounds.
  - W window shifts by R words; new words come from the σ0/σ1 schedule.
  - After 64/R cycles, go to ADD.
- **ADD:** H ← chain source + {a..h}, word-wise mod 2^32.
  - If the captured `in_last`=1: `H_out` ← new H, `out_valid` ← 1, go to OUT.
  - Otherwise go to IDLE and wait for the next block.
- **OUT:** `H_out` and `out_valid` hold stable until an edge with `out_ready`=1, then go to IDLE with `out_valid`=0.
  - `out_ready` is ignored while `out_valid`=0.
- **Single-block message:** `in_first`=`in_last`=1.
- **Reset mid-operation:** aborts the message in any state.
  - Next cycle: IDLE, `out_valid`=0, partial chain discarded.
- **Arithmetic:** all adds are 32-bit with wrap-around. No saturation and no carry out.

## Timing
- Accept edge to `out_valid` high: 64/R + 1 cycles. That is 65 for R=1 and 9 for R=8.
- Block-to-block throughput: one accept per 64/R + 2 cycles, since IDLE costs one cycle.
- `out_valid` drops on the edge that samples `out_ready`=1. `in_ready` rises the same cycle.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Configuration
- `SHA256_SHA224_EN` defined:
  - On an accepted `in_first` block with `mode224`=1, the chain loads the SHA-224 IV instead of `H_in`.
  - The mode is held for the whole message.
  - `H_out[31:0]` is forced to 0 in the final digest.
- Not defined: `mode224` is ignored, `H_in` is always used, and the full 256-bit digest is output.

## Structure
- Package `sha256_pkg`:
  - K[0:63] constant array.
  - IV256 and IV224 constants.
  - State enum.
  - Ch, Maj, Σ0, Σ1, σ0, σ1 functions.
- Sub-module `sha256_round`: one combinational round taking (a..h, W, K) and producing a..h. It is instantiated `ROUNDS_PER_CYCLE` times in a chain.

## Test plan
- **"abc", single block:** `H_in`=IV256, R=1 → `H_out`=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, `out_valid` exactly 65 cycles after accept. Repeat with R=8 → same digest in 9 cycles.
- **Empty message:** one block 0x80 followed by zeros → e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- **Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":**
  - Expect 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
  - `out_valid` stays 0 after block 1.
  - `in_ready` returns 64/R + 2 cycles after the first accept.
- **Backpressure:** hold `out_ready`=0 for 20 cycles → `H_out` and `out_valid` stable and `in_ready`=0 throughout. Raising `out_ready` → `in_ready`=1 on the next cycle.
- **Reset mid-ROUND:** assert `rst` at round 30 → `out_valid` stays 0, `in_ready`=1 after release. A following "abc" block produces the correct digest.
- **With `SHA256_SHA224_EN`:** "abc" with `mode224`=1 → `H_out`=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants, FSM state type and SHA-256 bit functions.
//   K      : the 64 round constants, indexed by round number.
//   IV256  : SHA-256 initial chaining value, word A in [255:224].
//   IV224  : SHA-224 initial chaining value, same packing.
//   state_e: engine control states.
package sha256_pkg;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_ADD   = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, f, g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, b, c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Word-wise mod 2^32 sum of two packed 8-word hash states.
    function automatic logic [255:0] add_words(input logic [255:0] x, y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round.
//   st_in  [255:0] : working variables a..h, a in [255:224].
//   w_in   [31:0]  : message schedule word for this round.
//   k_in   [31:0]  : round constant for this round.
//   st_out [255:0] : updated a..h, same packing.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] st_in,
    input  logic [31:0]  w_in,
    input  logic [31:0]  k_in,
    output logic [255:0] st_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = st_in;

    always_comb begin
        t1 = h + bsig1(e) + ch(e, f, g) + k_in + w_in;
        t2 = bsig0(a) + maj(a, b, c);
    end

    assign st_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream.sv
// sha256_stream: multi-block SHA-256 compression engine with internal chaining.
//   Parameter ROUNDS_PER_CYCLE (1, 2, 4 or 8): rounds applied per clock.
//   clk, rst          : rising-edge clock, synchronous active-high reset.
//   H_in [255:0]      : chaining value taken on an accepted first block.
//   in_block [511:0]  : pre-padded block, word 0 in [511:480].
//   in_first, in_last : message start / end markers for the offered block.
//   in_valid/in_ready : block handshake; in_ready is high only in IDLE.
//   mode224           : SHA-224 select, honoured only with SHA256_SHA224_EN.
//   H_out [255:0]     : final digest, word A in [255:224].
//   out_valid/out_ready: digest handshake; digest holds until taken.
// Optional feature macro: SHA256_SHA224_EN (SHA-224 IV and truncated digest).
module sha256_stream
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] H_in,
    input  logic [511:0] in_block,
    input  logic         in_first,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         mode224,
    output logic [255:0] H_out,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam int R        = ROUNDS_PER_CYCLE;
    localparam int LAST_CNT = 64 / R - 1;

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
        $error("sha256_stream: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_e       state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [255:0] h_q, h_d;         // chain value feeding the final add
    logic [255:0] wv_q, wv_d;       // working variables a..h
    logic [511:0] w_q, w_d;         // 16-word schedule window, oldest word on top
    logic         last_q, last_d;
    logic [255:0] hout_q, hout_d;
    logic         ov_q, ov_d;
    logic         mode_q, mode_d;

    logic         accept;
    logic [255:0] first_src;
    logic [255:0] chain_src;
    logic [255:0] h_sum;
    logic [31:0]  ext [16+R];
    logic [511:0] w_next;
    logic [255:0] rnd_out;

    assign in_ready  = !rst && (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign H_out     = hout_q;
    assign out_valid = ov_q;

`ifdef SHA256_SHA224_EN
    assign first_src = mode224 ? IV224 : H_in;
`else
    logic unused_mode224;
    assign unused_mode224 = mode224;
    assign first_src      = H_in;
`endif

    assign chain_src = in_first ? first_src : h_q;
    assign h_sum     = add_words(h_q, wv_q);

    // Schedule: the window plus R look-ahead words; later look-ahead words
    // depend on earlier ones, so they are built in order within one block.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ext[i] = w_q[511 - 32*i -: 32];
        end
        for (int i = 16; i < 16 + R; i++) begin
            ext[i] = ssig1(ext[i-2]) + ext[i-7] + ssig0(ext[i-15]) + ext[i-16];
        end
        w_next = '0;
        for (int i = 0; i < 16; i++) begin
            w_next[511 - 32*i -: 32] = ext[i+R];
        end
    end

    for (genvar j = 0; j < R; j++) begin : g_rnd
        logic [255:0] st_i;
        logic [255:0] st_o;
        logic [5:0]   k_idx;

        assign k_idx = 6'(int'(cnt_q) * R + j);

        if (j == 0) begin : g_head
            assign st_i = wv_q;
        end else begin : g_tail
            assign st_i = g_rnd[j-1].st_o;
        end

        sha256_round u_round (
            .st_in  (st_i),
            .w_in   (ext[j]),
            .k_in   (K[k_idx]),
            .st_out (st_o)
        );
    end

    assign rnd_out = g_rnd[R-1].st_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        wv_d    = wv_q;
        w_d     = w_q;
        last_d  = last_q;
        hout_d  = hout_q;
        ov_d    = ov_q;
        mode_d  = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    h_d     = chain_src;
                    wv_d    = chain_src;
                    w_d     = in_block;
                    last_d  = in_last;
                    cnt_d   = '0;
                    state_d = ST_ROUND;
`ifdef SHA256_SHA224_EN
                    // Mode latches at message start and sticks for its blocks.
                    if (in_first) begin
                        mode_d = mode224;
                    end
`endif
                end
            end
            ST_ROUND: begin
                wv_d = rnd_out;
                w_d  = w_next;
                if (cnt_q == 6'(LAST_CNT)) begin
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_ADD: begin
                h_d = h_sum;
                if (last_q) begin
                    hout_d = h_sum;
                    if (mode_q) begin
                        hout_d[31:0] = 32'h0;
                    end
                    ov_d    = 1'b1;
                    state_d = ST_OUT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            h_q     <= '0;
            last_q  <= 1'b0;
            hout_q  <= '0;
            ov_q    <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            last_q  <= last_d;
            hout_q  <= hout_d;
            ov_q    <= ov_d;
            mode_q  <= mode_d;
        end
    end

    // Datapath registers carry no reset; they are always reloaded on accept.
    always_ff @(posedge clk) begin
        wv_q <= wv_d;
        w_q  <= w_d;
    end

endmodule

// File: tb/tb_sha256_stream.sv
// tb_sha256_stream: directed-vector bench for sha256_stream with a scoreboard.
// Two engines are instantiated (1 and 8 rounds per clock); expected digests
// are queued per engine when a message is issued and popped by a monitor
// whenever that engine presents a digest that is being taken.
module tb_sha256_stream;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [511:0] B_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] B_TWO1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] B_TWO2 = {{15{32'h0}}, 32'h000001c0};

    localparam logic [255:0] D_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
`ifdef SHA256_SHA224_EN
    localparam logic [255:0] D_224 =
        256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7_00000000;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] h_in;
    logic [511:0] blk;
    logic         first, last, mode;
    logic         ivld1, ivld8, ordy;
    logic         ird1, ird8, ov1, ov8;
    logic [255:0] hout1, hout8;

    always #5 clk = ~clk;

    sha256_stream #(.ROUNDS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .H_in(h_in), .in_block(blk),
        .in_first(first), .in_last(last), .in_valid(ivld1), .in_ready(ird1),
        .mode224(mode), .H_out(hout1), .out_valid(ov1), .out_ready(ordy)
    );

    sha256_stream #(.ROUNDS_PER_CYCLE(8)) dut8 (
        .clk(clk), .rst(rst), .H_in(h_in), .in_block(blk),
        .in_first(first), .in_last(last), .in_valid(ivld8), .in_ready(ird8),
        .mode224(mode), .H_out(hout8), .out_valid(ov8), .out_ready(ordy)
    );

    int cyc = 0;
    int ov1_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;
    logic [255:0] exp1 [$];
    logic [255:0] exp8 [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ov1) ov1_cnt <= ov1_cnt + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: a digest is compared when it is presented and about to be taken.
    always @(negedge clk) begin
        if (!rst && ov1 && ordy) begin
            if (exp1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL digest_r1_unexpected: got %h expected no output", hout1);
            end else begin
                chk("digest_r1", hout1, exp1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov8 && ordy) begin
            if (exp8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL digest_r8_unexpected: got %h expected no output", hout8);
            end else begin
                chk("digest_r8", hout8, exp8.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns the index of the accept edge.
    task automatic send(input bit sel8, input logic [511:0] b, input logic f, input logic l,
                        input logic m, output int acc);
        int t;
        t = 0;
        blk   = b;
        first = f;
        last  = l;
        mode  = m;
        if (sel8) ivld8 = 1'b1;
        else      ivld1 = 1'b1;
        @(negedge clk);
        while (!(sel8 ? ird8 : ird1) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", t);
        end
        @(posedge clk);
        #1;
        acc   = cyc;
        ivld1 = 1'b0;
        ivld8 = 1'b0;
    endtask

    // Checks accept-to-out_valid distance; returns just after the next edge.
    task automatic wait_out(input bit sel8, input int acc, input int lat, input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!(sel8 ? ov8 : ov1) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(name, 256'(cyc - acc), 256'(lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, a1, a2, base, bad;
        logic [255:0] cap;

        rst = 1'b1; h_in = IV; blk = '0; first = 1'b0; last = 1'b0; mode = 1'b0;
        ivld1 = 1'b0; ivld8 = 1'b0; ordy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready_r1", 256'(ird1), 256'(0));
        chk("reset_in_ready_r8", 256'(ird8), 256'(0));
        chk("reset_out_valid", 256'(ov1), 256'(0));
        chk("reset_h_out", hout1, 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 256'(ird1), 256'(1));
        @(posedge clk); #1;

        // "abc", one block, R=1
        exp1.push_back(D_ABC);
        send(1'b0, B_ABC, 1'b1, 1'b1, 1'b0, a);
        wait_out(1'b0, a, 65, "latency_abc_r1");
        @(negedge clk);
        chk("in_ready_after_take", 256'(ird1), 256'(1));
        chk("out_valid_after_take", 256'(ov1), 256'(0));
        @(posedge clk); #1;

        // Empty message
        exp1.push_back(D_EMPTY);
        send(1'b0, B_EMPTY, 1'b1, 1'b1, 1'b0, a);
        wait_out(1'b0, a, 65, "latency_empty");

        // Two-block message with internal chaining
        exp1.push_back(D_TWO);
        base = ov1_cnt;
        send(1'b0, B_TWO1, 1'b1, 1'b0, 1'b0, a1);
        send(1'b0, B_TWO2, 1'b0, 1'b1, 1'b0, a2);
        chk("out_valid_after_block1", 256'(ov1_cnt - base), 256'(0));
        chk("block_spacing_r1", 256'(a2 - a1), 256'(66));
        wait_out(1'b0, a2, 65, "latency_two_block");

        // Backpressure: digest held for 20 cycles
        ordy = 1'b0;
        exp1.push_back(D_ABC);
        send(1'b0, B_ABC, 1'b1, 1'b1, 1'b0, a);
        wait_out(1'b0, a, 65, "latency_backpressure");
        cap = hout1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!ov1 || hout1 !== cap || ird1) bad++;
        end
        chk("backpressure_hold", 256'(bad), 256'(0));
        @(posedge clk); #1;
        ordy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("in_ready_after_release", 256'(ird1), 256'(1));
        chk("out_valid_after_release", 256'(ov1), 256'(0));
        @(posedge clk); #1;

        // Reset in the middle of the rounds
        send(1'b0, B_EMPTY, 1'b1, 1'b1, 1'b0, a);
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        base = ov1_cnt;
        repeat (80) @(negedge clk);
        chk("no_output_after_abort", 256'(ov1_cnt - base), 256'(0));
        chk("in_ready_after_abort", 256'(ird1), 256'(1));
        @(posedge clk); #1;
        exp1.push_back(D_ABC);
        send(1'b0, B_ABC, 1'b1, 1'b1, 1'b0, a);
        wait_out(1'b0, a, 65, "latency_after_abort");

`ifdef SHA256_SHA224_EN
        // SHA-224 "abc"
        exp1.push_back(D_224);
        send(1'b0, B_ABC, 1'b1, 1'b1, 1'b1, a);
        wait_out(1'b0, a, 65, "latency_sha224");
        mode = 1'b0;
`endif

        // R=8 engine: "abc" and the two-block message
        exp8.push_back(D_ABC);
        send(1'b1, B_ABC, 1'b1, 1'b1, 1'b0, a);
        wait_out(1'b1, a, 9, "latency_abc_r8");
        exp8.push_back(D_TWO);
        send(1'b1, B_TWO1, 1'b1, 1'b0, 1'b0, a1);
        send(1'b1, B_TWO2, 1'b0, 1'b1, 1'b0, a2);
        chk("block_spacing_r8", 256'(a2 - a1), 256'(10));
        wait_out(1'b1, a2, 9, "latency_two_block_r8");

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 256'(exp1.size() + exp8.size()), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
